// File: rtl/bus_arb2_if.sv
// Bundle of the two master request/response channels and the shared slave
// channel of the two-master bus arbiter.
interface bus_arb2_if;
    // Master 0 channel
    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_wdata_i;
    logic        m0_ack_o;
    logic        m0_resp_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    // Master 1 channel
    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_wdata_i;
    logic        m1_ack_o;
    logic        m1_resp_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    // Slave channel
    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_ack_i;
    logic        s_resp_i;
    logic [31:0] s_rdata_i;

    // Arbiter view: consumes master requests and slave replies.
    modport arb (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
        output m0_ack_o, m0_resp_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
        output m1_ack_o, m1_resp_o, m1_rdata_o, m1_err_o,
        output s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
        input  s_ack_i, s_resp_i, s_rdata_i
    );

    // Requesting masters' view.
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
        input  m0_ack_o, m0_resp_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
        input  m1_ack_o, m1_resp_o, m1_rdata_o, m1_err_o
    );

    // Downstream slave's view.
    modport slave (
        input  s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
        output s_ack_i, s_resp_i, s_rdata_i
    );
endinterface

// File: rtl/bus_arb2.sv
// Two-master round-robin bus arbiter with a single outstanding transaction.
// Writes complete at slave accept; reads complete with one registered
// response pulse, or an error response if the slave stays silent for
// TIMEOUT cycles after accepting.
module bus_arb2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    bus_arb2_if.arb   bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitResp} state_e;

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = m0, 1 = m1
    logic        ptr_q, ptr_d;       // master favoured on a tie
    logic [15:0] cnt_q, cnt_d;

    logic        m0_resp_q, m0_resp_d;
    logic        m0_err_q, m0_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic        m1_resp_q, m1_resp_d;
    logic        m1_err_q, m1_err_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic        in_req;
    logic        own_we;
    logic [31:0] own_addr;
    logic [3:0]  own_be;
    logic [31:0] own_wdata;
    logic        grant;
    logic        done;
    logic        done_err;
    logic [31:0] done_data;

    // Select the owner's request fields.
    always_comb begin
        own_we    = owner_q ? bus.m1_we_i    : bus.m0_we_i;
        own_addr  = owner_q ? bus.m1_addr_i  : bus.m0_addr_i;
        own_be    = owner_q ? bus.m1_be_i    : bus.m0_be_i;
        own_wdata = owner_q ? bus.m1_wdata_i : bus.m0_wdata_i;
    end

    // Slave request channel and master accept strobes; all zero outside REQ.
    always_comb begin
        in_req        = (state_q == StReq);
        bus.s_req_o   = in_req;
        bus.s_we_o    = in_req ? own_we    : 1'b0;
        bus.s_addr_o  = in_req ? own_addr  : 32'h0;
        bus.s_be_o    = in_req ? own_be    : 4'h0;
        bus.s_wdata_o = in_req ? own_wdata : 32'h0;
        bus.m0_ack_o  = in_req && bus.s_ack_i && !owner_q;
        bus.m1_ack_o  = in_req && bus.s_ack_i && owner_q;
    end

    // Registered response outputs.
    always_comb begin
        bus.m0_resp_o  = m0_resp_q;
        bus.m0_err_o   = m0_err_q;
        bus.m0_rdata_o = m0_rdata_q;
        bus.m1_resp_o  = m1_resp_q;
        bus.m1_err_o   = m1_err_q;
        bus.m1_rdata_o = m1_rdata_q;
    end

    // Next-state: arbitration, slave handshake, response/timeout completion.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant      = 1'b0;
        done       = 1'b0;
        done_err   = 1'b0;
        done_data  = 32'h0;
        m0_resp_d  = 1'b0;
        m0_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_resp_d  = 1'b0;
        m1_err_d   = 1'b0;
        m1_rdata_d = m1_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.m0_req_i || bus.m1_req_i) begin
                    // Pointer only matters when both request.
                    if (bus.m0_req_i && bus.m1_req_i) begin
                        grant = ptr_q;
                    end else begin
                        grant = bus.m1_req_i;
                    end
                    owner_d = grant;
                    ptr_d   = ~grant;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.s_ack_i) begin
                    cnt_d   = 16'h0;
                    state_d = own_we ? StIdle : StWaitResp;
                end
            end
            StWaitResp: begin
                if (bus.s_resp_i) begin
                    // A response on the final cycle still beats the timeout.
                    done      = 1'b1;
                    done_data = bus.s_rdata_i;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TimeoutCnt) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            if (owner_q) begin
                m1_resp_d  = 1'b1;
                m1_err_d   = done_err;
                m1_rdata_d = done_data;
            end else begin
                m0_resp_d  = 1'b1;
                m0_err_d   = done_err;
                m0_rdata_d = done_data;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            cnt_q      <= 16'h0;
            m0_resp_q  <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_resp_q  <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            m0_resp_q  <= m0_resp_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_resp_q  <= m1_resp_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_bus_arb2;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m_req[2];
    logic        m_we[2];
    logic [31:0] m_addr[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_wdata[2];
    logic        s_ack;
    logic        s_resp;
    logic [31:0] s_rdata;

    bus_arb2_if bus ();

    assign bus.m0_req_i   = m_req[0];
    assign bus.m0_we_i    = m_we[0];
    assign bus.m0_addr_i  = m_addr[0];
    assign bus.m0_be_i    = m_be[0];
    assign bus.m0_wdata_i = m_wdata[0];
    assign bus.m1_req_i   = m_req[1];
    assign bus.m1_we_i    = m_we[1];
    assign bus.m1_addr_i  = m_addr[1];
    assign bus.m1_be_i    = m_be[1];
    assign bus.m1_wdata_i = m_wdata[1];
    assign bus.s_ack_i    = s_ack;
    assign bus.s_resp_i   = s_resp;
    assign bus.s_rdata_i  = s_rdata;

    bus_arb2 #(.TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: is a transaction in flight, whose, has the
    // slave taken it, and how long has the read waited since.
    bit          md_busy;
    bit          md_acked;
    bit          md_own;
    bit          md_ptr;
    int          md_waited;
    bit          md_acc[2];
    logic        md_resp[2];
    logic        md_err[2];
    logic [31:0] md_rdata[2];
    bit          chk_on = 1'b0;
    logic        on_bus;

    // Advance the model with the inputs seen in the cycle that just ended.
    always @(posedge clk) begin
        md_acc[0]  = 1'b0;
        md_acc[1]  = 1'b0;
        md_resp[0] = 1'b0;
        md_resp[1] = 1'b0;
        md_err[0]  = 1'b0;
        md_err[1]  = 1'b0;
        if (rst) begin
            md_busy     = 1'b0;
            md_acked    = 1'b0;
            md_own      = 1'b0;
            md_ptr      = 1'b0;
            md_waited   = 0;
            md_rdata[0] = 32'h0;
            md_rdata[1] = 32'h0;
        end else if (!md_busy) begin
            if (m_req[0] || m_req[1]) begin
                md_own   = (m_req[0] && m_req[1]) ? md_ptr : m_req[1];
                md_ptr   = !md_own;
                md_busy  = 1'b1;
                md_acked = 1'b0;
            end
        end else if (!md_acked) begin
            if (s_ack) begin
                md_acc[md_own] = 1'b1;
                if (m_we[md_own]) begin
                    md_busy = 1'b0;
                end else begin
                    md_acked  = 1'b1;
                    md_waited = 0;
                end
            end
        end else begin
            md_waited++;
            if (s_resp) begin
                md_resp[md_own]  = 1'b1;
                md_rdata[md_own] = s_rdata;
                md_busy          = 1'b0;
            end else if (md_waited == TO) begin
                md_resp[md_own]  = 1'b1;
                md_err[md_own]   = 1'b1;
                md_rdata[md_own] = 32'h0;
                md_busy          = 1'b0;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            on_bus = md_busy && !md_acked;
            chk1("s_req", bus.s_req_o, on_bus);
            chk1("s_we", bus.s_we_o, on_bus ? m_we[md_own] : 1'b0);
            chk32("s_addr", bus.s_addr_o, on_bus ? m_addr[md_own] : 32'h0);
            chk32("s_be", {28'h0, bus.s_be_o}, on_bus ? {28'h0, m_be[md_own]} : 32'h0);
            chk32("s_wdata", bus.s_wdata_o, on_bus ? m_wdata[md_own] : 32'h0);
            chk1("m0_ack", bus.m0_ack_o, on_bus && s_ack && !md_own);
            chk1("m1_ack", bus.m1_ack_o, on_bus && s_ack && md_own);
            chk1("m0_resp", bus.m0_resp_o, md_resp[0]);
            chk1("m1_resp", bus.m1_resp_o, md_resp[1]);
            chk1("m0_err", bus.m0_err_o, md_err[0]);
            chk1("m1_err", bus.m1_err_o, md_err[1]);
            chk32("m0_rdata", bus.m0_rdata_o, md_rdata[0]);
            chk32("m1_rdata", bus.m1_rdata_o, md_rdata[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        m_req[i]   = 1'b1;
        m_we[i]    = we;
        m_addr[i]  = addr;
        m_be[i]    = be;
        m_wdata[i] = wdata;
    endtask

    int grants[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_req[i]   = 1'b0;
            m_we[i]    = 1'b0;
            m_addr[i]  = 32'h0;
            m_be[i]    = 4'h0;
            m_wdata[i] = 32'h0;
        end
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = 32'h0;
        rst     = 1'b1;
        tick();
        tick();
        #3;
        chk1("rst_s_req", bus.s_req_o, 1'b0);
        chk1("rst_m0_resp", bus.m0_resp_o, 1'b0);
        chk32("rst_m1_rdata", bus.m1_rdata_o, 32'h0);
        chk_on = 1'b1;
        tick();
        rst = 1'b0;

        // m0 read of 0x100: ack in cycle 3, slave data in cycle 6, response in cycle 7.
        set_req(0, 1'b0, 32'h100, 4'hF, 32'h0);
        tick();
        tick();
        tick();
        s_ack = 1'b1;
        #3;
        chk1("r031_m0_ack", bus.m0_ack_o, 1'b1);
        chk1("r031_m1_ack", bus.m1_ack_o, 1'b0);
        chk32("r031_s_addr", bus.s_addr_o, 32'h100);
        tick();
        s_ack    = 1'b0;
        m_req[0] = 1'b0;
        tick();
        tick();
        s_resp  = 1'b1;
        s_rdata = 32'hCAFEF00D;
        tick();
        s_resp  = 1'b0;
        s_rdata = 32'h0;
        #3;
        chk1("r031_m0_resp", bus.m0_resp_o, 1'b1);
        chk1("r031_m0_err", bus.m0_err_o, 1'b0);
        chk32("r031_m0_rdata", bus.m0_rdata_o, 32'hCAFEF00D);
        chk1("r031_m1_resp", bus.m1_resp_o, 1'b0);
        tick();
        #3;
        chk1("r031_pulse_end", bus.m0_resp_o, 1'b0);
        chk32("r031_rdata_hold", bus.m0_rdata_o, 32'hCAFEF00D);

        // m1 write mirrored onto the slave bus, accepted without response.
        set_req(1, 1'b1, 32'h200, 4'h3, 32'h1234);
        tick();
        s_ack = 1'b1;
        #3;
        chk1("r033_s_we", bus.s_we_o, 1'b1);
        chk32("r033_s_addr", bus.s_addr_o, 32'h200);
        chk32("r033_s_be", {28'h0, bus.s_be_o}, 32'h3);
        chk32("r033_s_wdata", bus.s_wdata_o, 32'h1234);
        chk1("r033_m1_ack", bus.m1_ack_o, 1'b1);
        chk1("r033_m0_ack", bus.m0_ack_o, 1'b0);
        tick();
        s_ack    = 1'b0;
        m_req[1] = 1'b0;
        #3;
        chk1("r033_idle", bus.s_req_o, 1'b0);
        chk1("r033_no_resp", bus.m1_resp_o, 1'b0);
        tick();

        // Read timeout after four silent cycles, then a late response is ignored.
        set_req(0, 1'b0, 32'h300, 4'hF, 32'h0);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack    = 1'b0;
        m_req[0] = 1'b0;
        tick();
        tick();
        tick();
        #3;
        chk1("r034_not_early", bus.m0_resp_o, 1'b0);
        tick();
        #3;
        chk1("r034_resp", bus.m0_resp_o, 1'b1);
        chk1("r034_err", bus.m0_err_o, 1'b1);
        chk32("r034_rdata", bus.m0_rdata_o, 32'h0);
        s_resp  = 1'b1;
        s_rdata = 32'h77777777;
        tick();
        s_resp = 1'b0;
        #3;
        chk1("r034_late_m0", bus.m0_resp_o, 1'b0);
        chk1("r034_late_m1", bus.m1_resp_o, 1'b0);

        // Response on the last timeout cycle wins over the error.
        set_req(0, 1'b0, 32'h304, 4'hF, 32'h0);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack    = 1'b0;
        m_req[0] = 1'b0;
        tick();
        tick();
        tick();
        s_resp  = 1'b1;
        s_rdata = 32'h5A5A0001;
        tick();
        s_resp = 1'b0;
        #3;
        chk1("r024_resp", bus.m0_resp_o, 1'b1);
        chk1("r024_err", bus.m0_err_o, 1'b0);
        chk32("r024_rdata", bus.m0_rdata_o, 32'h5A5A0001);

        // Reset during a read wait abandons it; m1 is served next.
        set_req(0, 1'b0, 32'h308, 4'hF, 32'h0);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack    = 1'b0;
        m_req[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        s_resp  = 1'b1;
        s_rdata = 32'hDEADBEEF;
        tick();
        s_resp = 1'b0;
        #3;
        chk1("r035_m0_quiet", bus.m0_resp_o, 1'b0);
        chk1("r035_m1_quiet", bus.m1_resp_o, 1'b0);
        chk32("r035_rdata_clr", bus.m0_rdata_o, 32'h0);
        set_req(1, 1'b1, 32'h30C, 4'hF, 32'h11);
        tick();
        s_ack = 1'b1;
        #3;
        chk1("r035_m1_ack", bus.m1_ack_o, 1'b1);
        tick();
        s_ack    = 1'b0;
        m_req[1] = 1'b0;
        tick();

        // Grant held on m0 while the slave stalls; m1 follows.
        set_req(0, 1'b1, 32'h400, 4'h1, 32'hA0);
        tick();
        for (int c = 0; c < 10; c++) begin
            if (c == 2) set_req(1, 1'b1, 32'h500, 4'h2, 32'hB0);
            #3;
            chk32("r036_hold_addr", bus.s_addr_o, 32'h400);
            tick();
        end
        s_ack = 1'b1;
        #3;
        chk1("r036_m0_ack", bus.m0_ack_o, 1'b1);
        chk1("r036_m1_wait", bus.m1_ack_o, 1'b0);
        tick();
        s_ack    = 1'b0;
        m_req[0] = 1'b0;
        tick();
        s_ack = 1'b1;
        #3;
        chk32("r036_m1_addr", bus.s_addr_o, 32'h500);
        chk1("r036_m1_ack", bus.m1_ack_o, 1'b1);
        tick();
        s_ack    = 1'b0;
        m_req[1] = 1'b0;

        // Both masters request continuously from reset: grants alternate from m0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 32'h600, 4'hF, 32'h1);
        set_req(1, 1'b1, 32'h700, 4'hF, 32'h2);
        s_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (bus.m0_ack_o) grants.push_back(0);
            if (bus.m1_ack_o) grants.push_back(1);
            tick();
        end
        chk1("r032_grant_count", grants.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < grants.size(); k++) begin
            chk32($sformatf("r032_grant%0d", k), 32'(grants[k]), 32'(k % 2));
        end
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        s_ack    = 1'b0;
        tick();
        tick();

        // Randomized traffic, stray responses and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (m_req[i] && md_acc[i]) m_req[i] = 1'b0;
                if (!m_req[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
                end
            end
            s_ack   = 1'($urandom_range(0, 1));
            s_resp  = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
        end
        tick();
        rst      = 1'b0;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        s_ack    = 1'b0;
        s_resp   = 1'b0;
        tick();
        tick();
        #3;
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arb2.md
BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the number of cycles to wait for a read response before an error completion; legal range 1..65535.
REQ-002 clk_i  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 m0_req_i / m1_req_i  input  1  master request.
REQ-005 mN_we_i  input  1  write enable (1 = write).
REQ-006 mN_addr_i  input  32  byte address.
REQ-007 mN_be_i  input  4  byte enables.
REQ-008 mN_wdata_i  input  32  write data.
REQ-009 mN_ack_o  output  1  request accepted.
REQ-010 mN_resp_o  output  1  read data valid (one-cycle pulse).
REQ-011 mN_rdata_o  output  32  read data.
REQ-012 mN_err_o  output  1  read timed out; qualified by mN_resp_o.
REQ-013 s_req_o, s_we_o, s_addr_o[31:0], s_be_o[3:0], s_wdata_o[31:0]  output  slave request channel.
REQ-014 s_ack_i  input  1; s_resp_i  input  1; s_rdata_i  input  32.  Slave accept, read-valid and read data.

Function
REQ-015 Bus protocol: a master SHALL hold req and all request fields stable until req&ack in the same cycle; writes complete at ack with no resp; reads complete with exactly one resp pulse after ack.
REQ-016 FSM states SHALL be IDLE, REQ and WAIT_RESP.
REQ-017 IDLE: if any mN_req_i is high, the block SHALL latch owner (round-robin, below) and enter REQ on the next cycle; otherwise it SHALL stay in IDLE.
REQ-018 Round-robin: a priority pointer SHALL favour its master when both request; after each grant the pointer SHALL point to the non-granted master.
REQ-019 REQ: s_req_o=1 and all s_* fields SHALL be muxed from owner; non-owner requests are ignored; the grant SHALL NOT change until s_ack_i.
REQ-020 REQ with s_ack_i=1: owner ack_o=1 combinationally in the same cycle; write -> IDLE; read -> WAIT_RESP with timeout counter cleared.
REQ-021 When not in REQ, s_req_o SHALL be 0 and s_we_o/s_addr_o/s_be_o/s_wdata_o SHALL be 0.
REQ-022 WAIT_RESP with s_resp_i=1: owner resp_o=1, rdata_o=s_rdata_i and err_o=0 SHALL be registered, presented the cycle after s_resp_i, then the FSM returns to IDLE.
REQ-023 WAIT_RESP timeout: the counter SHALL increment each cycle without s_resp_i; on reaching TIMEOUT, owner resp_o=1, err_o=1 and rdata_o=0 for one cycle, then IDLE.
REQ-024 s_resp_i on the same cycle the counter reaches TIMEOUT SHALL win (normal completion, err_o=0).
REQ-025 s_resp_i arriving outside WAIT_RESP (late or stray) SHALL be ignored with no master resp.
REQ-026 Non-owner resp_o/err_o SHALL be 0; mN_rdata_o SHALL hold its last value between responses.
REQ-027 Back-to-back: a new grant MAY be made in the IDLE cycle directly after completion; each transaction has a minimum 1-cycle IDLE gap.
REQ-028 Only one transaction SHALL be outstanding at any time.

Reset
REQ-029 On rst_i: state=IDLE, pointer=m0, counter=0, owner=m0; all ack/resp/err outputs 0; rdata_o 0; s_* outputs 0.
REQ-030 Reset asserted mid-transaction SHALL abandon it silently; a subsequent s_resp_i SHALL be ignored per REQ-025.

Verification
REQ-031 m0 read of 0x100, slave acks at cycle 3 and resps at cycle 6 with 0xCAFEF00D -> m0_ack_o at cycle 3, m0_resp_o=1 and m0_rdata_o=0xCAFEF00D at cycle 7, m1 outputs quiet.
REQ-032 m0 and m1 both request from reset with slave always acking -> grants alternate m0, m1, m0, m1 with no grant lost.
REQ-033 m1 write to 0x200, be=0x3, data 0x1234 -> s_* mirrors exactly; m1_ack_o with s_ack_i; no resp; IDLE next.
REQ-034 TIMEOUT=4, slave never responds -> m0_resp_o=1, m0_err_o=1, m0_rdata_o=0 four cycles after entering WAIT_RESP; a late s_resp_i is ignored.
REQ-035 rst_i pulsed in WAIT_RESP, then s_resp_i -> no resp on either master; the next m1 request is granted after pointer reset.
REQ-036 m0 request held while slave withholds ack for 10 cycles and m1 raises its request -> s_* stays on m0 throughout; m1 is granted after m0 completes.
